imem_boot_loader: RTL and testbench



---
 rtl/imem_boot_loader_pkg.sv | 31 +++
 rtl/imem_word_assembler.sv | 48 ++++
 rtl/imem_boot_loader.sv | 136 +++++++++++++
 tb/tb_imem_boot_loader.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_boot_loader_pkg.sv
// ============================================================================
// Module      : imem_boot_loader_pkg
// Description : Shared state encoding, length width and memory defaults
//               for the instruction-memory boot loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_boot_loader_pkg;

    localparam int c_LEN_W     = 16;
    localparam int c_DEPTH_DEF = 1024;
    localparam int c_AW_DEF    = 10;

    typedef enum logic [2:0] {
        ST_LEN_LO = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_DATA   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RUN    = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

    // States in which the loader is willing to take a byte.
    function automatic logic is_loading(input state_t s);
        return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA);
    endfunction

endpackage

`default_nettype wire

// File: rtl/imem_word_assembler.sv
// ============================================================================
// Module      : imem_word_assembler
// Description : Packs four little-endian bytes into a 32-bit word and flags
//               the byte that completes it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_word_assembler
    import imem_boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_ready
);

    logic [1:0]  r_cnt;
    logic [23:0] r_lanes;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= 2'd0;
            r_lanes <= 24'd0;
        end else if (i_clear) begin
            r_cnt   <= 2'd0;
            r_lanes <= 24'd0;
        end else if (i_byte_valid) begin
            r_cnt <= r_cnt + 2'd1;
            case (r_cnt)
                2'd0:    r_lanes[7:0]   <= i_byte;
                2'd1:    r_lanes[15:8]  <= i_byte;
                2'd2:    r_lanes[23:16] <= i_byte;
                default: ;
            endcase
        end
    end

    // The top lane is never stored: it is the byte arriving on the final beat.
    assign o_word       = {i_byte, r_lanes};
    assign o_word_ready = i_byte_valid && (r_cnt == 2'd3);

endmodule

`default_nettype wire

// File: rtl/imem_boot_loader.sv
// ============================================================================
// Module      : imem_boot_loader
// Description : Loads a length-prefixed byte stream into instruction memory,
//               then hands the address bus to the fetch PC and releases the CPU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int DEPTH = c_DEPTH_DEF,
    parameter int AW    = c_AW_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        reload,
    input  logic [31:0] pc,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_we,
    output logic        cpu_rst,
    output logic        load_done,
    output logic        load_err
);

    localparam logic [c_LEN_W-1:0] c_DEPTH_L = c_LEN_W'(DEPTH);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_LEN_W-1:0] r_len;
    logic [AW:0]        r_word_cnt;
    logic               r_rx_ready;
    logic               r_mem_we;
    logic [31:0]        r_mem_din;
    logic               r_cpu_rst;
    logic               r_load_done;
    logic               r_load_err;

    logic               w_accept;
    logic               w_reload;
    logic [c_LEN_W-1:0] w_len_full;
    logic [c_LEN_W-1:0] w_cnt_inc;
    logic [31:0]        w_word;
    logic               w_word_ready;

    assign w_accept   = rx_valid && r_rx_ready;
    assign w_reload   = reload && ((r_state == ST_RUN) || (r_state == ST_ERROR));
    assign w_len_full = {rx_data, r_len[7:0]};
    // Counter is one bit wider than the address so a full-depth load never wraps.
    assign w_cnt_inc  = c_LEN_W'(r_word_cnt) + c_LEN_W'(1);

    imem_word_assembler u_asm (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_reload),
        .i_byte_valid (w_accept && (r_state == ST_DATA)),
        .i_byte       (rx_data),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LEN_LO: if (w_accept) w_state_nxt = ST_LEN_HI;
            ST_LEN_HI: begin
                if (w_accept) begin
                    if (w_len_full == '0)
                        w_state_nxt = ST_RUN;
                    else if (w_len_full > c_DEPTH_L)
                        w_state_nxt = ST_ERROR;
                    else
                        w_state_nxt = ST_DATA;
                end
            end
            ST_DATA:   if (w_word_ready) w_state_nxt = ST_WRITE;
            ST_WRITE:  w_state_nxt = (w_cnt_inc == r_len) ? ST_RUN : ST_DATA;
            ST_RUN,
            ST_ERROR:  if (reload) w_state_nxt = ST_LEN_LO;
            default:   w_state_nxt = ST_LEN_LO;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge
    // as the state itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_LEN_LO;
            r_len       <= '0;
            r_word_cnt  <= '0;
            r_rx_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_din   <= 32'd0;
            r_cpu_rst   <= 1'b1;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rx_ready  <= is_loading(w_state_nxt);
            r_mem_we    <= (w_state_nxt == ST_WRITE);
            r_cpu_rst   <= (w_state_nxt != ST_RUN);
            r_load_done <= (w_state_nxt == ST_RUN);
            r_load_err  <= (w_state_nxt == ST_ERROR);

            if (w_accept && (r_state == ST_LEN_LO))
                r_len[7:0] <= rx_data;
            if (w_accept && (r_state == ST_LEN_HI))
                r_len[15:8] <= rx_data;
            if (w_word_ready)
                r_mem_din <= w_word;
            if (r_state == ST_WRITE)
                r_word_cnt <= r_word_cnt + 1'b1;

            if (w_reload) begin
                r_len      <= '0;
                r_word_cnt <= '0;
            end
        end
    end

    assign rx_ready  = r_rx_ready;
    assign mem_we    = r_mem_we;
    assign mem_din   = r_mem_din;
    assign cpu_rst   = r_cpu_rst;
    assign load_done = r_load_done;
    assign load_err  = r_load_err;
    assign mem_addr  = (r_state == ST_RUN) ? pc
                                           : {{(30-AW){1'b0}}, r_word_cnt[AW-1:0], 2'b00};

endmodule

`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
// ============================================================================
// Module      : tb_imem_boot_loader
// Description : Directed self-checking bench for imem_boot_loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_boot_loader;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        reload;
    logic [31:0] pc;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_we;
    logic        cpu_rst;
    logic        load_done;
    logic        load_err;

    int tests_run;
    int fails;

    logic [31:0] mem [0:1023];
    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];

    imem_boot_loader dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .reload    (reload),
        .pc        (pc),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_we    (mem_we),
        .cpu_rst   (cpu_rst),
        .load_done (load_done),
        .load_err  (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor sampled on the falling edge; mem_we lasts exactly one cycle.
    always @(negedge clk) begin
        if (mem_we) begin
            mem[mem_addr[11:2]] <= mem_din;
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_din);
        end
    end

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_byte(input logic [7:0] b);
        int cyc;
        rx_data  = b;
        rx_valid = 1'b1;
        cyc = 0;
        while (!rx_ready && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (!rx_ready) begin
            tests_run++; fails++;
            $display("FAIL send_byte_timeout: rx_ready=%0b required 1", rx_ready);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic send_byte_stall(input logic [7:0] b);
        int idle;
        idle = 0;
        while ($urandom_range(0, 1) == 0 && idle < 4) begin
            rx_valid = 1'b0;
            @(negedge clk);
            idle++;
        end
        send_byte(b);
    endtask

    task automatic wait_run(input string name);
        int cyc;
        cyc = 0;
        while (!load_done && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (load_done !== 1'b1) begin
            fails++;
            $display("FAIL %s_run_timeout: load_done=%0b required 1", name, load_done);
        end
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({rx_ready, mem_we, cpu_rst, load_done, load_err} !== 5'b00100 ||
            mem_din !== 32'd0 || mem_addr !== 32'd0) begin
            fails++;
            $display("FAIL reset_values: rdy/we/crst/done/err=%b din=%h addr=%h required 00100 0 0",
                     {rx_ready, mem_we, cpu_rst, load_done, load_err}, mem_din, mem_addr);
        end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (rx_ready !== 1'b1 || cpu_rst !== 1'b1) begin
            fails++;
            $display("FAIL reset_release: rx_ready=%0b cpu_rst=%0b required 1 1", rx_ready, cpu_rst);
        end
    endtask

    task automatic test_basic();
        clear_log();
        send_byte(8'h02); send_byte(8'h00);
        send_word(32'h12345678);
        send_word(32'hDEADBEEF);
        wait_run("basic");
        tests_run++;
        if (log_addr.size() != 2) begin
            fails++;
            $display("FAIL basic_write_count: got %0d required 2", log_addr.size());
        end else if (log_addr[0] !== 32'h0 || log_data[0] !== 32'h12345678 ||
                     log_addr[1] !== 32'h4 || log_data[1] !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL basic_writes: %h@%h %h@%h required 12345678@0 deadbeef@4",
                     log_data[0], log_addr[0], log_data[1], log_addr[1]);
        end
        pc = 32'h00000004;
        #1;
        tests_run++;
        if (cpu_rst !== 1'b0 || load_done !== 1'b1 || mem_addr !== 32'h4 || rx_ready !== 1'b0) begin
            fails++;
            $display("FAIL basic_run: cpu_rst=%0b done=%0b addr=%h rdy=%0b required 0 1 00000004 0",
                     cpu_rst, load_done, mem_addr, rx_ready);
        end
        pc = 32'h0000_0ABC;
        #1;
        tests_run++;
        if (mem_addr !== 32'h0000_0ABC) begin
            fails++;
            $display("FAIL basic_pc_follow: addr=%h required 00000abc", mem_addr);
        end
        pulse_reload();
        tests_run++;
        if (rx_ready !== 1'b1 || cpu_rst !== 1'b1 || load_done !== 1'b0 || mem_addr !== 32'h0) begin
            fails++;
            $display("FAIL basic_reload: rdy=%0b crst=%0b done=%0b addr=%h required 1 1 0 0",
                     rx_ready, cpu_rst, load_done, mem_addr);
        end
    endtask

    task automatic test_zero_len();
        clear_log();
        send_byte(8'h00); send_byte(8'h00);
        tests_run++;
        if (load_done !== 1'b1 || cpu_rst !== 1'b0 || log_addr.size() != 0) begin
            fails++;
            $display("FAIL zero_len: done=%0b crst=%0b writes=%0d required 1 0 0",
                     load_done, cpu_rst, log_addr.size());
        end
        // Bytes offered in RUN must not be taken.
        rx_data = 8'h5A; rx_valid = 1'b1;
        repeat (3) @(negedge clk);
        rx_valid = 1'b0;
        tests_run++;
        if (rx_ready !== 1'b0 || load_done !== 1'b1) begin
            fails++;
            $display("FAIL run_ignores_bytes: rdy=%0b done=%0b required 0 1", rx_ready, load_done);
        end
        pulse_reload();
    endtask

    task automatic test_too_long();
        send_byte(8'h01); send_byte(8'h04);
        tests_run++;
        if (load_err !== 1'b1 || cpu_rst !== 1'b1 || rx_ready !== 1'b0 || load_done !== 1'b0) begin
            fails++;
            $display("FAIL too_long: err=%0b crst=%0b rdy=%0b done=%0b required 1 1 0 0",
                     load_err, cpu_rst, rx_ready, load_done);
        end
        rx_data = 8'h33; rx_valid = 1'b1;
        repeat (4) @(negedge clk);
        rx_valid = 1'b0;
        tests_run++;
        if (load_err !== 1'b1 || rx_ready !== 1'b0) begin
            fails++;
            $display("FAIL error_sticky: err=%0b rdy=%0b required 1 0", load_err, rx_ready);
        end
        pulse_reload();
        tests_run++;
        if (load_err !== 1'b0 || rx_ready !== 1'b1 || cpu_rst !== 1'b1) begin
            fails++;
            $display("FAIL error_reload: err=%0b rdy=%0b crst=%0b required 0 1 1",
                     load_err, rx_ready, cpu_rst);
        end
    endtask

    task automatic test_stall();
        logic [31:0] w [3];
        w[0] = 32'h11223344; w[1] = 32'hA5A55A5A; w[2] = 32'h0BADF00D;
        clear_log();
        send_byte_stall(8'h03); send_byte_stall(8'h00);
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 4; i++) send_byte_stall(w[k][8*i +: 8]);
        wait_run("stall");
        tests_run++;
        if (log_addr.size() != 3) begin
            fails++;
            $display("FAIL stall_write_count: got %0d required 3", log_addr.size());
        end else if (log_addr[0] !== 32'h0 || log_data[0] !== 32'h11223344 ||
                     log_addr[1] !== 32'h4 || log_data[1] !== 32'hA5A55A5A ||
                     log_addr[2] !== 32'h8 || log_data[2] !== 32'h0BADF00D) begin
            fails++;
            $display("FAIL stall_writes: %h@%h %h@%h %h@%h required 11223344@0 a5a55a5a@4 0badf00d@8",
                     log_data[0], log_addr[0], log_data[1], log_addr[1], log_data[2], log_addr[2]);
        end
        pulse_reload();
    endtask

    task automatic test_reset_mid();
        clear_log();
        send_byte(8'h02); send_byte(8'h00);
        send_word(32'hCAFEBABE);
        send_byte(8'h11); send_byte(8'h22);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (cpu_rst !== 1'b1 || rx_ready !== 1'b0 || mem_addr !== 32'h0) begin
            fails++;
            $display("FAIL mid_reset_asserted: crst=%0b rdy=%0b addr=%h required 1 0 0",
                     cpu_rst, rx_ready, mem_addr);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if (log_addr.size() != 1 || log_data[0] !== 32'hCAFEBABE || log_addr[0] !== 32'h0) begin
            fails++;
            $display("FAIL mid_reset_writes: count=%0d first=%h required 1 cafebabe",
                     log_addr.size(), (log_data.size() > 0) ? log_data[0] : 32'hX);
        end
        tests_run++;
        if (cpu_rst !== 1'b1 || rx_ready !== 1'b1 || load_done !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_state: crst=%0b rdy=%0b done=%0b required 1 1 0",
                     cpu_rst, rx_ready, load_done);
        end
    endtask

    task automatic test_full_and_reload();
        int bad;
        clear_log();
        send_byte(8'h00); send_byte(8'h04);
        for (int k = 0; k < 1024; k++) send_word(32'hA0000000 | k);
        wait_run("full");
        bad = 0;
        if (log_addr.size() == 1024)
            for (int k = 0; k < 1024; k++)
                if (log_addr[k] !== 32'(4 * k) || log_data[k] !== (32'hA0000000 | k)) bad++;
        tests_run++;
        if (log_addr.size() != 1024 || bad != 0) begin
            fails++;
            $display("FAIL full_contents: writes=%0d bad=%0d required 1024 0", log_addr.size(), bad);
        end
        tests_run++;
        if (log_addr.size() != 1024 || log_addr[1023] !== 32'hFFC || cpu_rst !== 1'b0) begin
            fails++;
            $display("FAIL full_last: last_addr=%h crst=%0b required 00000ffc 0",
                     (log_addr.size() > 0) ? log_addr[log_addr.size()-1] : 32'hX, cpu_rst);
        end
        pulse_reload();
        clear_log();
        send_byte(8'h01); send_byte(8'h00);
        send_word(32'h55667788);
        wait_run("rewrite");
        tests_run++;
        if (log_addr.size() != 1 || log_addr[0] !== 32'h0 ||
            mem[0] !== 32'h55667788 || mem[1] !== 32'hA0000001 || mem[1023] !== 32'hA00003FF) begin
            fails++;
            $display("FAIL rewrite: writes=%0d mem0=%h mem1=%h mem1023=%h required 1 55667788 a0000001 a00003ff",
                     log_addr.size(), mem[0], mem[1], mem[1023]);
        end
    endtask

    initial begin
        tests_run = 0;
        fails     = 0;
        rst       = 1'b1;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        reload    = 1'b0;
        pc        = 32'h0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_zero_len();
        test_too_long();
        test_stall();
        test_reset_mid();
        test_full_and_reload();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

`default_nettype wire
